proj_trig_monitor: RTL and testbench
====================================

# proj_trig_monitor

Receive-side checker for projector trigger pulse trains. After being armed, it watches the trigger line returned from the projector (or looped back from the trigger generator). It counts pulses and measures each pulse's high width and the low spacing before it, in clk cycles. It flags any deviation from the expected count, width and spacing, and sits beside the trigger generator so firmware can confirm that every commanded exposure trigger was delivered.

## Interface
Parameters:
- TIMEOUT, 32'd100_000_000: maximum low cycles allowed while waiting for the next rising edge.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle start pulse; clears status and begins monitoring.
- trig_in  in  1  monitored trigger line.
- exp_num  in  32  expected pulse count.
- exp_width  in  32  expected high width in cycles.
- exp_spacing  in  32  expected low spacing between pulses in cycles.
- tol  in  8  allowed absolute error on width and spacing in cycles.
- busy  out  1  high while in WAIT_RISE, HIGH or LOW.
- done  out  1  high in DONE; stays high until the next arm.
- pulse_cnt  out  32  pulses completed since arm.
- last_width  out  32  high width of the most recent pulse.
- last_spacing  out  32  low spacing before the most recent pulse.
- err_width  out  1  sticky; a width was outside exp_width±tol.
- err_spacing  out  1  sticky; a spacing was outside exp_spacing±tol.
- err_extra  out  1  sticky; a rising edge was seen in DONE.
- err_timeout  out  1  sticky; TIMEOUT expired before exp_num pulses.

## Operation
- Sample `s` = trig_in, synchronized or not per the Configuration section; `s_d` = `s` delayed one cycle.
- Rising edge: s=1 and s_d=0. Falling edge: s=0 and s_d=1.
- The `s_d` register resets to 0.
- States:
  - IDLE: reset state.
  - WAIT_RISE: after arm, until the first rising edge. The low counter runs.
  - HIGH: the high counter increments each cycle that s=1.
    - On a falling edge: last_width←high counter; err_width set if the width is out of tolerance; pulse_cnt++.
    - Go to DONE if the new pulse_cnt equals exp_num, else go to LOW with the low counter = 1.
  - LOW: the low counter increments each cycle that s=0.
    - On a rising edge: last_spacing←low counter; err_spacing set if the spacing is out of tolerance; go to HIGH with the high counter = 1.
  - DONE: done=1. Any rising edge sets err_extra. Remains in DONE until arm.
- Entry into HIGH from WAIT_RISE loads the high counter = 1; no spacing check is made for the first pulse.
- Timeout: in WAIT_RISE or LOW, when the low counter reaches TIMEOUT, set err_timeout and go to DONE.
- Arm:
  - Accepted in any state.
  - Clears pulse_cnt, last_width, last_spacing, all err_* flags and both counters.
  - Goes to WAIT_RISE, or to DONE directly if exp_num==0.
  - Arm has priority over any edge in the same cycle; that edge is ignored.
  - If s=1 at arm, the pulse is not counted until a genuine rising edge occurs.
- Tolerance check: 33-bit signed difference, |meas−exp| ≤ {24'b0,tol}.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- exp_* inputs are sampled continuously; they must be held stable from arm until done.

## Timing
- Reset values: every output is 0 and state is IDLE.
- A high level lasting W sampled cycles gives last_width==W.
- last_width and pulse_cnt update on the clock edge that samples the first low `s`, so they are visible one cycle later.
- last_spacing behaves the same way on the first high `s`.
- done asserts the cycle after the final falling edge is detected.
- busy deasserts in the same cycle that done asserts.
- Synchronizer latency adds 2 cycles to every event; measured widths and spacings are unaffected.
- Reset mid-train returns to IDLE immediately; the train is abandoned and no flags are retained.

## Configuration
- PROJ_TRIG_MON_SYNC_EN defined: trig_in passes through a two-flop synchronizer (reset to 0) before `s`. Use this when the trigger comes from an off-chip projector.
- Not defined: `s` = trig_in directly. trig_in must then be synchronous to clk; event latency is 2 cycles lower.

## Test plan
- Arm with exp_num=4, exp_width=10, exp_spacing=20, tol=0 and drive 4 pulses of 10 high / 20 low → pulse_cnt=4, last_width=10, last_spacing=20, done=1, all err_* = 0.
- Same settings with the third pulse 13 cycles high and tol=2 → err_width=1, last_width after that pulse = 13, done=1 after pulse 4; with tol=3 → err_width=0.
- Five pulses against exp_num=3 → done after pulse 3, err_extra=1 on the 4th rising edge, pulse_cnt stays 3.
- TIMEOUT=50 and only 2 of 4 pulses driven → err_timeout=1 and done=1 exactly 50 low cycles after the 2nd falling edge, pulse_cnt=2.
- Arm with exp_num=0 → done=1 the next cycle, busy never asserts.
- Assert rst_n=0 in the middle of pulse 2 → all outputs 0 immediately; re-arm followed by a clean train passes. Run this case both with and without PROJ_TRIG_MON_SYNC_EN and check the 2-cycle latency difference.

Source files
------------

// File: rtl/proj_trig_monitor_if.sv
// Bundle of the control, trigger and status signals of proj_trig_monitor.
// The master side (firmware/bench) drives arm, trig_in and expectations; the slave side is the monitor.
interface proj_trig_monitor_if;
   logic        arm;
   logic        trig_in;
   logic [31:0] exp_num;
   logic [31:0] exp_width;
   logic [31:0] exp_spacing;
   logic [7:0]  tol;
   logic        busy;
   logic        done;
   logic [31:0] pulse_cnt;
   logic [31:0] last_width;
   logic [31:0] last_spacing;
   logic        err_width;
   logic        err_spacing;
   logic        err_extra;
   logic        err_timeout;

   modport master (
      output arm, trig_in, exp_num, exp_width, exp_spacing, tol,
      input  busy, done, pulse_cnt, last_width, last_spacing,
             err_width, err_spacing, err_extra, err_timeout
   );

   modport slave (
      input  arm, trig_in, exp_num, exp_width, exp_spacing, tol,
      output busy, done, pulse_cnt, last_width, last_spacing,
             err_width, err_spacing, err_extra, err_timeout
   );
endinterface

// File: rtl/proj_trig_monitor.sv
// Receive-side checker for projector trigger trains: counts pulses, measures width/spacing, flags deviations.
// Optional feature macro PROJ_TRIG_MON_SYNC_EN: two-flop synchronizer on trig_in for off-chip triggers.
module proj_trig_monitor #(
   parameter logic [31:0] TIMEOUT = 32'd100_000_000
) (
   input  logic            clk,
   input  logic            rst_n,
   proj_trig_monitor_if.slave mon
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WAIT_RISE = 3'd1;
   localparam logic [2:0] ST_HIGH      = 3'd2;
   localparam logic [2:0] ST_LOW       = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   function automatic logic [31:0] sat_inc(input logic [31:0] x);
      return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
   endfunction

   function automatic logic within_tol(input logic [31:0] meas, input logic [31:0] expv,
                                       input logic [7:0] tol);
      logic signed [32:0] diff;
      logic        [32:0] mag;
      diff = $signed({1'b0, meas}) - $signed({1'b0, expv});
      mag  = diff[32] ? $unsigned(-diff) : $unsigned(diff);
      return (mag <= {25'd0, tol});
   endfunction

   logic        s_s;
   logic        s_d_r;
   logic        rise_s;
   logic        fall_s;
   logic [2:0]  state_r,        state_nxt_s;
   logic [31:0] high_r,         high_nxt_s;
   logic [31:0] low_r,          low_nxt_s;
   logic [31:0] pulse_cnt_r,    pulse_cnt_nxt_s;
   logic [31:0] last_width_r,   last_width_nxt_s;
   logic [31:0] last_spacing_r, last_spacing_nxt_s;
   logic        err_width_r,    err_width_nxt_s;
   logic        err_spacing_r,  err_spacing_nxt_s;
   logic        err_extra_r,    err_extra_nxt_s;
   logic        err_timeout_r,  err_timeout_nxt_s;
   logic        busy_r;
   logic        done_r;
   logic [31:0] cnt_inc_s;

`ifdef PROJ_TRIG_MON_SYNC_EN
   logic [1:0] sync_r;

   // Two-flop synchronizer for an asynchronous trigger source.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= 2'b00;
      end else begin
         sync_r <= {sync_r[0], mon.trig_in};
      end
   end

   assign s_s = sync_r[1];
`else
   assign s_s = mon.trig_in;
`endif

   assign rise_s    = s_s & ~s_d_r;
   assign fall_s    = ~s_s & s_d_r;
   assign cnt_inc_s = sat_inc(pulse_cnt_r);

   // Next-state and measurement logic; arm overrides any edge seen in the same cycle.
   always_comb begin
      state_nxt_s        = state_r;
      high_nxt_s         = high_r;
      low_nxt_s          = low_r;
      pulse_cnt_nxt_s    = pulse_cnt_r;
      last_width_nxt_s   = last_width_r;
      last_spacing_nxt_s = last_spacing_r;
      err_width_nxt_s    = err_width_r;
      err_spacing_nxt_s  = err_spacing_r;
      err_extra_nxt_s    = err_extra_r;
      err_timeout_nxt_s  = err_timeout_r;
      if (mon.arm) begin
         state_nxt_s        = (mon.exp_num == 32'd0) ? ST_DONE : ST_WAIT_RISE;
         high_nxt_s         = 32'd0;
         low_nxt_s          = 32'd0;
         pulse_cnt_nxt_s    = 32'd0;
         last_width_nxt_s   = 32'd0;
         last_spacing_nxt_s = 32'd0;
         err_width_nxt_s    = 1'b0;
         err_spacing_nxt_s  = 1'b0;
         err_extra_nxt_s    = 1'b0;
         err_timeout_nxt_s  = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_nxt_s = ST_IDLE;
            end
            ST_WAIT_RISE: begin
               if (rise_s) begin
                  state_nxt_s = ST_HIGH;
                  high_nxt_s  = 32'd1;
               end else if (low_r >= TIMEOUT) begin
                  err_timeout_nxt_s = 1'b1;
                  state_nxt_s       = ST_DONE;
               end else if (!s_s) begin
                  low_nxt_s = sat_inc(low_r);
               end else begin
                  low_nxt_s = low_r;
               end
            end
            ST_HIGH: begin
               if (fall_s) begin
                  last_width_nxt_s = high_r;
                  err_width_nxt_s  = err_width_r | ~within_tol(high_r, mon.exp_width, mon.tol);
                  pulse_cnt_nxt_s  = cnt_inc_s;
                  if (cnt_inc_s == mon.exp_num) begin
                     state_nxt_s = ST_DONE;
                  end else begin
                     state_nxt_s = ST_LOW;
                     low_nxt_s   = 32'd1;
                  end
               end else if (s_s) begin
                  high_nxt_s = sat_inc(high_r);
               end else begin
                  high_nxt_s = high_r;
               end
            end
            ST_LOW: begin
               if (rise_s) begin
                  last_spacing_nxt_s = low_r;
                  err_spacing_nxt_s  = err_spacing_r | ~within_tol(low_r, mon.exp_spacing, mon.tol);
                  state_nxt_s        = ST_HIGH;
                  high_nxt_s         = 32'd1;
               end else if (low_r >= TIMEOUT) begin
                  err_timeout_nxt_s = 1'b1;
                  state_nxt_s       = ST_DONE;
               end else if (!s_s) begin
                  low_nxt_s = sat_inc(low_r);
               end else begin
                  low_nxt_s = low_r;
               end
            end
            ST_DONE: begin
               if (rise_s) begin
                  err_extra_nxt_s = 1'b1;
               end else begin
                  err_extra_nxt_s = err_extra_r;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_d_r          <= 1'b0;
         state_r        <= ST_IDLE;
         high_r         <= 32'd0;
         low_r          <= 32'd0;
         pulse_cnt_r    <= 32'd0;
         last_width_r   <= 32'd0;
         last_spacing_r <= 32'd0;
         err_width_r    <= 1'b0;
         err_spacing_r  <= 1'b0;
         err_extra_r    <= 1'b0;
         err_timeout_r  <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
      end else begin
         s_d_r          <= s_s;
         state_r        <= state_nxt_s;
         high_r         <= high_nxt_s;
         low_r          <= low_nxt_s;
         pulse_cnt_r    <= pulse_cnt_nxt_s;
         last_width_r   <= last_width_nxt_s;
         last_spacing_r <= last_spacing_nxt_s;
         err_width_r    <= err_width_nxt_s;
         err_spacing_r  <= err_spacing_nxt_s;
         err_extra_r    <= err_extra_nxt_s;
         err_timeout_r  <= err_timeout_nxt_s;
         busy_r         <= (state_nxt_s == ST_WAIT_RISE) || (state_nxt_s == ST_HIGH) ||
                           (state_nxt_s == ST_LOW);
         done_r         <= (state_nxt_s == ST_DONE);
      end
   end

   assign mon.busy         = busy_r;
   assign mon.done         = done_r;
   assign mon.pulse_cnt    = pulse_cnt_r;
   assign mon.last_width   = last_width_r;
   assign mon.last_spacing = last_spacing_r;
   assign mon.err_width    = err_width_r;
   assign mon.err_spacing  = err_spacing_r;
   assign mon.err_extra    = err_extra_r;
   assign mon.err_timeout  = err_timeout_r;

endmodule

// File: tb/tb_proj_trig_monitor.sv
// Scoreboard bench for proj_trig_monitor: a pulse-level model predicts done time and final status per train.
// Works with or without PROJ_TRIG_MON_SYNC_EN (expected done time shifts by the synchronizer latency).
module tb_proj_trig_monitor;
   localparam logic [31:0] TMO = 32'd50;
`ifdef PROJ_TRIG_MON_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      int exp_num; int exp_w; int exp_sp; int tol;
      int lead_hi; int lead_lo; int n;
      int w[8]; int sp[8];
   } train_t;

   typedef struct {
      bit is_snap; int cyc;
      int pc; int lw; int ls;
      bit ew; bit es; bit ex; bit eto;
      bit busy; bit done; bit busy_seen;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   snap_req = 1'b0;
   exp_t sbq[$];

   proj_trig_monitor_if mon();
   proj_trig_monitor #(.TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .mon(mon));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic cmp_rec(input exp_t e);
      chk("pulse_cnt",    mon.pulse_cnt,    e.pc);
      chk("last_width",   mon.last_width,   e.lw);
      chk("last_spacing", mon.last_spacing, e.ls);
      chk("err_width",    mon.err_width,    e.ew);
      chk("err_spacing",  mon.err_spacing,  e.es);
      chk("err_extra",    mon.err_extra,    e.ex);
      chk("err_timeout",  mon.err_timeout,  e.eto);
      chk("busy",         mon.busy,         e.busy);
      chk("done",         mon.done,         e.done);
   endtask

   // Monitor: pops the scoreboard when done rises or when the driver requests a status snapshot.
   initial begin : monitor
      bit   done_prev;
      bit   busy_seen;
      exp_t e;
      done_prev = 1'b0;
      busy_seen = 1'b0;
      forever begin
         @(negedge clk);
         chk("busy_done_exclusive", mon.busy & mon.done, 0);
         if (mon.arm) busy_seen = 1'b0;
         else if (mon.busy) busy_seen = 1'b1;
         if (mon.done && !done_prev) begin
            if (sbq.size() == 0 || sbq[0].is_snap) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("busy_seen", busy_seen, e.busy_seen);
               cmp_rec(e);
            end
         end
         if (snap_req) begin
            while (sbq.size() > 0 && !sbq[0].is_snap) begin
               e = sbq.pop_front();
               chk("done_missing", 0, 1);
            end
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               cmp_rec(e);
            end
            snap_req = 1'b0;
         end else if (sbq.size() > 0 && !sbq[0].is_snap && cyc > sbq[0].cyc + 20) begin
            e = sbq.pop_front();
            chk("done_late", cyc, e.cyc);
         end
         done_prev = mon.done;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic request_snap(input exp_t e);
      e.is_snap = 1'b1;
      sbq.push_back(e);
      snap_req = 1'b1;
      for (int i = 0; i < 4 && snap_req; i++) @(negedge clk);
      #1;
      if (snap_req) begin
         chk("snapshot_timeout", 0, 1);
         snap_req = 1'b0;
      end
   endtask

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   function automatic train_t mk(input int en, input int ew, input int es, input int tol, input int n);
      train_t t;
      t.exp_num = en; t.exp_w = ew; t.exp_sp = es; t.tol = tol;
      t.lead_hi = 0; t.lead_lo = 5; t.n = n;
      for (int k = 0; k < 8; k++) begin
         t.w[k]  = ew;
         t.sp[k] = es;
      end
      return t;
   endfunction

   // Drives one train after arm; abort_at >= 0 asserts reset at that level index instead of finishing.
   task automatic run_train(input train_t t, input int abort_at);
      int   lv[$];
      exp_t e;
      exp_t z;
      bit   dn;
      bit   extra;
      int   cnt, idx, fall_prev, done_at, arm_cyc;
      lv = {};
      for (int i = 0; i < t.lead_hi; i++) lv.push_back(1);
      for (int i = 0; i < t.lead_lo; i++) lv.push_back(0);
      for (int k = 0; k < t.n; k++) begin
         for (int i = 0; i < t.w[k]; i++) lv.push_back(1);
         if (k < t.n - 1) for (int i = 0; i < t.sp[k]; i++) lv.push_back(0);
      end
      for (int i = 0; i < int'(TMO) + 30; i++) lv.push_back(0);

      e = '{default: 0};
      dn = (t.exp_num == 0);
      extra = 1'b0;
      cnt = 0; fall_prev = 0; done_at = 0;
      idx = t.lead_hi + t.lead_lo;
      for (int k = 0; k < t.n; k++) begin
         if (k > 0 && !dn) begin
            if (t.sp[k-1] > int'(TMO)) begin
               dn = 1'b1; e.eto = 1'b1; done_at = fall_prev + int'(TMO);
            end else begin
               e.ls = t.sp[k-1];
               if (iabs(t.sp[k-1] - t.exp_sp) > t.tol) e.es = 1'b1;
            end
         end
         if (dn) begin
            extra = 1'b1;
         end else begin
            e.lw = t.w[k];
            if (iabs(t.w[k] - t.exp_w) > t.tol) e.ew = 1'b1;
            cnt++;
            fall_prev = idx + t.w[k];
            if (cnt == t.exp_num) begin
               dn = 1'b1; done_at = fall_prev;
            end
         end
         idx += t.w[k] + ((k < t.n - 1) ? t.sp[k] : 0);
      end
      if (!dn) begin
         e.eto = 1'b1; done_at = fall_prev + int'(TMO);
      end
      e.pc = cnt; e.busy = 1'b0; e.done = 1'b1; e.busy_seen = (t.exp_num != 0);

      mon.exp_num = 32'(t.exp_num); mon.exp_width = 32'(t.exp_w);
      mon.exp_spacing = 32'(t.exp_sp); mon.tol = 8'(t.tol);
      for (int i = 0; i < 3; i++) begin
         step();
         mon.trig_in = (t.lead_hi > 0);
      end
      step();
      mon.arm = 1'b1;
      mon.trig_in = (t.lead_hi > 0);
      arm_cyc = cyc + 1;
      e.cyc = (t.exp_num == 0) ? arm_cyc : arm_cyc + 1 + done_at + LAT;
      if (abort_at < 0) sbq.push_back(e);
      for (int i = 0; i < lv.size(); i++) begin
         step();
         mon.arm = 1'b0;
         if (i == abort_at) begin
            rst_n = 1'b0;
            z = '{default: 0};
            request_snap(z);
            mon.trig_in = 1'b0;
            step();
            rst_n = 1'b1;
            return;
         end
         mon.trig_in = lv[i][0];
      end
      step();
      e.ex = extra;
      request_snap(e);
   endtask

   initial begin : watchdog
      #3_000_000;
      checks++;
      failures++;
      $display("FAIL global_watchdog actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : driver
      train_t t;
      exp_t   z;
      rst_n = 1'b0;
      mon.arm = 1'b0; mon.trig_in = 1'b0;
      mon.exp_num = 32'd0; mon.exp_width = 32'd0; mon.exp_spacing = 32'd0; mon.tol = 8'd0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      z = '{default: 0};
      request_snap(z);

      // exp_num==0: done right after arm, busy never; a later pulse is extra
      run_train(mk(0, 10, 20, 0, 1), -1);
      // clean train of 4
      run_train(mk(4, 10, 20, 0, 4), -1);
      // wide third pulse against two tolerances
      t = mk(4, 10, 20, 2, 4); t.w[2] = 13;
      run_train(t, -1);
      t.tol = 3;
      run_train(t, -1);
      // extra pulses after completion
      run_train(mk(3, 10, 20, 0, 5), -1);
      // timeout after 2 of 4 pulses
      run_train(mk(4, 10, 20, 0, 2), -1);
      // spacing right at and just past the timeout
      t = mk(2, 5, 50, 0, 2);
      run_train(t, -1);
      t.sp[0] = 51;
      run_train(t, -1);
      // armed while the line is high
      t = mk(3, 8, 12, 1, 3); t.lead_hi = 6;
      run_train(t, -1);
      // reset in the middle of pulse 2, then a clean train
      t = mk(4, 10, 20, 0, 4);
      run_train(t, t.lead_lo + 10 + 20 + 5);
      run_train(t, -1);

      for (int r = 0; r < 20; r++) begin
         t.exp_num = int'($urandom_range(1, 6));
         t.exp_w   = int'($urandom_range(4, 15));
         t.exp_sp  = int'($urandom_range(5, 30));
         t.tol     = int'($urandom_range(0, 3));
         t.lead_hi = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
         t.lead_lo = int'($urandom_range(2, 10));
         t.n       = int'($urandom_range((t.exp_num > 1) ? t.exp_num - 1 : 1, t.exp_num + 2));
         for (int k = 0; k < 8; k++) begin
            t.w[k]  = t.exp_w + int'($urandom_range(0, 6)) - 3;
            t.sp[k] = ($urandom_range(0, 9) == 0) ? int'(TMO) + int'($urandom_range(1, 8))
                                                 : t.exp_sp + int'($urandom_range(0, 6)) - 3;
         end
         run_train(t, -1);
      end

      repeat (5) step();
      chk("scoreboard_empty", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
